nasti_addr_mapper: RTL and testbench
====================================

NASTI_ADDR_MAPPER -- requirements
Module: nasti_addr_mapper

Interface
REQ-001 Parameter C_NASTI_ADDR_WIDTH, default 32: request byte-address width.
REQ-002 Parameter C_ID_WIDTH, default 4: request ID width.
REQ-003 s_nasti_clk  in  1: single clock; all logic on rising edge.
REQ-004 s_nasti_reset  in  1: reset, synchronous and active-high.
REQ-005 add_map  in  2: address-map select from the configuration register block.
REQ-006 in_valid  in  1; in_ready  out  1: request handshake.
REQ-007 in_addr  in  C_NASTI_ADDR_WIDTH; in_write  in  1; in_id  in  C_ID_WIDTH: request payload.
REQ-008 out_valid  out  1; out_ready  in  1: translated-request handshake.
REQ-009 out_bank  out  3; out_row  out  14; out_col  out  10; out_write  out  1; out_id  out  C_ID_WIDTH; out_oor  out  1 (out-of-range flag).

Function
REQ-010 The block shall use word index w = in_addr[29:3] (27 bits, 64-bit beats) and ignore in_addr[2:0].
REQ-011 Map 00 (RBC): col=w[9:0], bank=w[12:10], row=w[26:13].
REQ-012 Map 01 (BRC): col=w[9:0], row=w[23:10], bank=w[26:24].
REQ-013 Map 10 (RCB, bank-interleaved): bank=w[2:0], col=w[12:3], row=w[26:13].
REQ-014 Map 11 is reserved and shall translate identically to map 00.
REQ-015 out_oor=1 if any in_addr bit above bit 29 is set; bank/row/col shall then be 0. The request is still forwarded.
REQ-016 Translation shall use the internal register cur_map, not add_map directly.
REQ-017 cur_map shall load add_map only in cycles where state is EMPTY and in_valid=0, so a map change never splits a burst of back-to-back requests.
REQ-018 The datapath shall be an output register plus one skid register, with states EMPTY, ONE (output valid) and TWO (output and skid valid).
REQ-019 in_ready shall be registered, equal to (state != TWO).
REQ-020 Latency: a request accepted in cycle N shall appear on out_* in cycle N+1 when the output register is free.
REQ-021 EMPTY->ONE on accept. ONE->ONE on accept with out_ready=1. ONE->TWO on accept with out_ready=0. ONE->EMPTY on out_ready=1 with no accept.
REQ-022 TWO->ONE on out_ready=1: the skid entry moves to the output register; in_ready=1 from the next cycle.
REQ-023 In TWO, in_valid shall be ignored. No request shall be dropped, duplicated or reordered.
REQ-024 out_* payload shall hold stable while out_valid=1 and out_ready=0.
REQ-025 Sustained throughput shall be one request per cycle when out_ready is held high.

Reset
REQ-026 On s_nasti_reset=1, the following shall take effect at the next edge: state=EMPTY, out_valid=0, in_ready=0, cur_map=00, and all out_* payload and skid contents 0.
REQ-027 in_ready shall rise in the first cycle after reset deassertion.
REQ-028 Reset mid-operation shall discard buffered requests without emitting them.

Structure
REQ-029 Package nasti_ddr_pkg shall hold:
- the map enum (MAP_RBC, MAP_BRC, MAP_RCB, MAP_RSVD);
- the bank/row/col width constants (3/14/10);
- a request struct;
- a pure function map_addr(map, addr) returning bank/row/col/oor.
REQ-030 No sub-module; the skid buffer and FSM stay in nasti_addr_mapper.

Verification
REQ-031 add_map=00, single request addr 0x0000_2408 id 3 -> next cycle: out_valid=1, bank=1, row=0, col=0x081, oor=0, id=3.
REQ-032 Same address with add_map=10 set while idle -> bank=1, col=0x090, row=0.
REQ-033 Same address with add_map=01 -> bank=0, row=1, col=0x081.
REQ-034 addr 0x4000_0000 -> oor=1, bank=row=col=0, forwarded normally.
REQ-035 Backpressure: four back-to-back requests, out_ready=0 for 3 cycles then 1 -> in_ready falls after 2 accepts, then all 4 emerge in order with no loss.
REQ-036 add_map changes from 00 to 10 during a continuous in_valid=1 stream -> all requests use 00 until an idle EMPTY cycle, then 10.

Source files
------------

// File: rtl/nasti_ddr_pkg.sv
// Shared DDR address-map definitions: map select, DDR coordinate widths,
// the buffered request record and the address-to-bank/row/col translation.
package nasti_ddr_pkg;

    localparam int BANK_W     = 3;
    localparam int ROW_W      = 14;
    localparam int COL_W      = 10;
    localparam int MAP_ADDR_W = 64;

    typedef enum logic [1:0] {
        MAP_RBC  = 2'b00,
        MAP_BRC  = 2'b01,
        MAP_RCB  = 2'b10,
        MAP_RSVD = 2'b11
    } map_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              oor;
    } ddr_loc_t;

    typedef struct packed {
        ddr_loc_t loc;
        logic     write;
    } req_t;

    // Word index is the 64-bit beat number; anything above bit 29 is out of range
    // and yields an all-zero coordinate with the oor flag set.
    function automatic ddr_loc_t map_addr(input map_e map, input logic [MAP_ADDR_W-1:0] addr);
        logic [26:0] w;
        ddr_loc_t    r;
        w     = addr[29:3];
        r     = '0;
        r.oor = |addr[MAP_ADDR_W-1:30];
        if (!r.oor) begin
            case (map)
                MAP_BRC: begin
                    r.col  = w[9:0];
                    r.row  = w[23:10];
                    r.bank = w[26:24];
                end
                MAP_RCB: begin
                    r.bank = w[2:0];
                    r.col  = w[12:3];
                    r.row  = w[26:13];
                end
                default: begin
                    r.col  = w[9:0];
                    r.bank = w[12:10];
                    r.row  = w[26:13];
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/nasti_addr_mapper.sv
// Translates NASTI byte addresses into DDR bank/row/col through an output
// register plus skid register, so the input side can run at one request per cycle.
module nasti_addr_mapper
    import nasti_ddr_pkg::*;
#(
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_ID_WIDTH         = 4
) (
    input  logic                          s_nasti_clk,
    input  logic                          s_nasti_reset,
    input  logic [1:0]                    add_map,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [C_NASTI_ADDR_WIDTH-1:0] in_addr,
    input  logic                          in_write,
    input  logic [C_ID_WIDTH-1:0]         in_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BANK_W-1:0]             out_bank,
    output logic [ROW_W-1:0]              out_row,
    output logic [COL_W-1:0]              out_col,
    output logic                          out_write,
    output logic [C_ID_WIDTH-1:0]         out_id,
    output logic                          out_oor,
    output logic [1:0]                    dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never drops and payload never changes until that transfer happens.

    state_e                state;
    map_e                  cur_map;
    req_t                  in_req;
    req_t                  out_q;
    req_t                  skid_q;
    logic [C_ID_WIDTH-1:0] out_id_q;
    logic [C_ID_WIDTH-1:0] skid_id_q;
    logic                  accept;

    always_comb begin
        in_req.loc   = map_addr(cur_map, MAP_ADDR_W'(in_addr));
        in_req.write = in_write;
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge s_nasti_clk) begin
        if (s_nasti_reset) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            cur_map   <= MAP_RBC;
            out_q     <= '0;
            skid_q    <= '0;
            out_id_q  <= '0;
            skid_id_q <= '0;
        end else begin
            // Map switches only in a truly idle cycle so a burst never mixes maps.
            if (state == ST_EMPTY && !in_valid) begin
                cur_map <= map_e'(add_map);
            end
            case (state)
                ST_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_q     <= in_req;
                        out_id_q  <= in_id;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    in_ready <= 1'b1;
                    if (accept && out_ready) begin
                        out_q    <= in_req;
                        out_id_q <= in_id;
                    end else if (accept) begin
                        skid_q    <= in_req;
                        skid_id_q <= in_id;
                        in_ready  <= 1'b0;
                        state     <= ST_TWO;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        out_q    <= skid_q;
                        out_id_q <= skid_id_q;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_bank  = out_q.loc.bank;
    assign out_row   = out_q.loc.row;
    assign out_col   = out_q.loc.col;
    assign out_oor   = out_q.loc.oor;
    assign out_write = out_q.write;
    assign out_id    = out_id_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_nasti_addr_mapper.sv
// Directed bench for nasti_addr_mapper: map translations, out-of-range,
// backpressure through the skid register, map switching and mid-run reset.
module tb_nasti_addr_mapper;

    logic        clk;
    logic        rst;
    logic [1:0]  add_map;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic        in_write;
    logic [3:0]  in_id;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_bank;
    logic [13:0] out_row;
    logic [9:0]  out_col;
    logic        out_write;
    logic [3:0]  out_id;
    logic        out_oor;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];

    nasti_addr_mapper #(
        .C_NASTI_ADDR_WIDTH(32),
        .C_ID_WIDTH(4)
    ) dut (
        .s_nasti_clk  (clk),
        .s_nasti_reset(rst),
        .add_map      (add_map),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_write     (in_write),
        .in_id        (in_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bank     (out_bank),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_write    (out_write),
        .out_id       (out_id),
        .out_oor      (out_oor),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs driven 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [3:0] id, input logic wr);
        in_valid = 1'b1;
        in_addr  = addr;
        in_id    = id;
        in_write = wr;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_addr  = '0;
        in_id    = '0;
        in_write = 1'b0;
    endtask

    initial begin
        int accepts;
        int sent;
        int got;
        int ready_fall_at;
        logic [13:0] e;

        rst = 1'b1; add_map = 2'b00; out_ready = 1'b1;
        idle();
        step();
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_payload", {out_bank, out_row, out_col, out_oor, out_write, out_id}, 32'd0);

        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Map 00 (RBC)
        drive_req(32'h0000_2408, 4'd3, 1'b0);
        step();
        idle();
        chk("rbc_valid", 32'(out_valid), 32'd1);
        chk("rbc_bank", 32'(out_bank), 32'd1);
        chk("rbc_row", 32'(out_row), 32'd0);
        chk("rbc_col", 32'(out_col), 32'h081);
        chk("rbc_oor", 32'(out_oor), 32'd0);
        chk("rbc_id", 32'(out_id), 32'd3);
        step();
        chk("rbc_drained", 32'(out_valid), 32'd0);

        // Map 10 (RCB) loaded during an idle cycle
        add_map = 2'b10;
        step();
        drive_req(32'h0000_2408, 4'd3, 1'b0);
        step();
        idle();
        chk("rcb_bank", 32'(out_bank), 32'd1);
        chk("rcb_col", 32'(out_col), 32'h090);
        chk("rcb_row", 32'(out_row), 32'd0);
        step();

        // Map 01 (BRC)
        add_map = 2'b01;
        step();
        drive_req(32'h0000_2408, 4'd3, 1'b0);
        step();
        idle();
        chk("brc_bank", 32'(out_bank), 32'd0);
        chk("brc_row", 32'(out_row), 32'd1);
        chk("brc_col", 32'(out_col), 32'h081);
        step();

        // Out of range, still forwarded
        add_map = 2'b00;
        step();
        drive_req(32'h4000_0000, 4'd5, 1'b1);
        step();
        idle();
        chk("oor_valid", 32'(out_valid), 32'd1);
        chk("oor_flag", 32'(out_oor), 32'd1);
        chk("oor_coords", {out_bank, out_row, out_col}, 32'd0);
        chk("oor_write", 32'(out_write), 32'd1);
        chk("oor_id", 32'(out_id), 32'd5);
        step();

        // Backpressure: four requests, out_ready low for the first three cycles
        sent = 0; got = 0; accepts = 0; ready_fall_at = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 3);
            if (sent < 4) drive_req(32'h0000_1000 + 32'(sent) * 32'd8, 4'(sent + 8), 1'b0);
            else idle();
            if (!in_ready && ready_fall_at < 0) ready_fall_at = accepts;
            if (cyc == 2) chk("bp_hold_id", 32'(out_id), 32'd8);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_out", 32'(out_id), 32'hffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("bp_order", {out_id, out_col}, 32'(e));
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({4'(sent + 8), 10'h200 + 10'(sent)});
                sent++;
                accepts++;
            end
            step();
        end
        idle();
        out_ready = 1'b1;
        chk("bp_ready_fall_after", 32'(ready_fall_at), 32'd2);
        chk("bp_all_out", 32'(got), 32'd4);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Map change requested mid-stream takes effect only after an idle EMPTY cycle
        add_map = 2'b10;
        for (int k = 0; k < 4; k++) begin
            chk("stream_ready", 32'(in_ready), 32'd1);
            drive_req(32'h0000_2408, 4'(k), 1'b0);
            step();
            chk("stream_old_map_col", 32'(out_col), 32'h081);
            chk("stream_id", 32'(out_id), 32'(k));
        end
        idle();
        step();
        chk("stream_empty", 32'(out_valid), 32'd0);
        step();
        drive_req(32'h0000_2408, 4'd7, 1'b0);
        step();
        idle();
        chk("stream_new_map_col", 32'(out_col), 32'h090);
        chk("stream_new_map_bank", 32'(out_bank), 32'd1);
        step();

        // Reset while both registers hold requests discards them
        out_ready = 1'b0;
        drive_req(32'h0000_2408, 4'd1, 1'b0);
        step();
        drive_req(32'h0000_2410, 4'd2, 1'b0);
        step();
        idle();
        chk("pre_rst_state_two", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_payload", {out_bank, out_row, out_col, out_id}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("midrst_no_emit", 32'(out_valid), 32'd0);
        chk("midrst_ready_rise", 32'(in_ready), 32'd1);
        step();
        chk("midrst_still_empty", 32'(out_valid), 32'd0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
